// File: rtl/rtc_field_pkg.sv
// rtl/rtc_field_pkg.sv - field codes, FSM encoding and BCD limit helpers for the RTC field editor
package rtc_field_pkg;

   localparam logic [3:0] FIELD_SEC      = 4'd1;
   localparam logic [3:0] FIELD_MIN      = 4'd2;
   localparam logic [3:0] FIELD_HOUR     = 4'd3;
   localparam logic [3:0] FIELD_DAY      = 4'd4;
   localparam logic [3:0] FIELD_MONTH    = 4'd5;
   localparam logic [3:0] FIELD_YEAR     = 4'd6;
   localparam logic [3:0] FIELD_TMR_HOUR = 4'd7;
   localparam logic [3:0] FIELD_TMR_MIN  = 4'd8;
   localparam logic [3:0] FIELD_TMR_SEC  = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_EDIT  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   function automatic logic field_valid(input logic [3:0] code);
      return (code >= FIELD_SEC) && (code <= FIELD_TMR_SEC);
   endfunction

   function automatic logic [7:0] field_min(input logic [3:0] code);
      case (code)
         FIELD_DAY, FIELD_MONTH: return 8'h01;
         default:                return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] field_max(input logic [3:0] code);
      case (code)
         FIELD_SEC, FIELD_MIN, FIELD_TMR_MIN, FIELD_TMR_SEC: return 8'h59;
         FIELD_HOUR, FIELD_TMR_HOUR:                         return 8'h23;
         FIELD_DAY:                                          return 8'h31;
         FIELD_MONTH:                                        return 8'h12;
         FIELD_YEAR:                                         return 8'h99;
         default:                                            return 8'h00;
      endcase
   endfunction

   // Valid BCD orders the same as binary, so plain compares clamp correctly;
   // any non-decimal digit falls back to the field minimum.
   function automatic logic [7:0] load_clamp(input logic [7:0] cur,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi);
      if ((cur[7:4] > 4'd9) || (cur[3:0] > 4'd9)) return lo;
      if (cur < lo) return lo;
      if (cur > hi) return hi;
      return cur;
   endfunction

endpackage

// File: rtl/bcd2_step.sv
// rtl/bcd2_step.sv - combinational one-step up/down of a two-digit BCD value within limits
module bcd2_step (
   input  logic [7:0] val,
   input  logic       up,
   input  logic [7:0] min,
   input  logic [7:0] max,
   input  logic       wrap,
   output logic [7:0] next_val
);

   logic [3:0] tens_inc;
   logic [3:0] tens_dec;
   logic [3:0] units_inc;
   logic [3:0] units_dec;

   // Digit-wise carry/borrow, with wrap or saturate at the field limits
   always_comb begin
      tens_inc  = val[7:4] + 4'd1;
      tens_dec  = val[7:4] - 4'd1;
      units_inc = val[3:0] + 4'd1;
      units_dec = val[3:0] - 4'd1;
      next_val  = val;
      if (up) begin
         if (val >= max)            next_val = wrap ? min : max;
         else if (val[3:0] == 4'd9) next_val = {tens_inc, 4'h0};
         else                       next_val = {val[7:4], units_inc};
      end else begin
         if (val <= min)            next_val = wrap ? max : min;
         else if (val[3:0] == 4'd0) next_val = {tens_dec, 4'h9};
         else                       next_val = {val[7:4], units_dec};
      end
   end

endmodule

// File: rtl/rtc_field_editor.sv
// rtl/rtc_field_editor.sv - edits one BCD RTC field with key auto-repeat and writes it back
module rtc_field_editor
   import rtc_field_pkg::*;
#(
   parameter int TICK_DIV     = 10_000_000,
   parameter int REPEAT_TICKS = 4,
   parameter bit WRAP_EN      = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] sel_i,
   input  logic [7:0] cur_i,
   input  logic       inc_i,
   input  logic       dec_i,
   input  logic       commit_i,
   input  logic       wr_ack_i,
   output logic [7:0] value_o,
   output logic       wr_o,
   output logic [3:0] wr_addr_o,
   output logic [7:0] wr_data_o,
   output logic       busy_o
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int RW = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS);

   state_t     state, state_nxt;
   logic [3:0] field_q, field_nxt;
   logic [7:0] value_q, value_nxt;
   logic       wr_q, wr_nxt;
   logic [3:0] addr_q, addr_nxt;
   logic [7:0] data_q, data_nxt;

   logic [PW-1:0] pre_cnt;
   logic [RW-1:0] rep_cnt;
   logic          tick;
   logic          inc_q, dec_q;
   logic          step_q, step_up_q;
   logic          one_key, rise;
   logic [7:0]    field_lo, field_hi, step_val;

   assign tick     = (pre_cnt == PRE_LAST);
   assign one_key  = inc_i ^ dec_i;
   assign rise     = (inc_i & ~dec_i & ~inc_q) | (dec_i & ~inc_i & ~dec_q);
   assign field_lo = field_min(field_q);
   assign field_hi = field_max(field_q);

   bcd2_step u_step (
      .val      (value_q),
      .up       (step_up_q),
      .min      (field_lo),
      .max      (field_hi),
      .wrap     (WRAP_EN),
      .next_val (step_val)
   );

   // Free-running step prescaler and key history for edge detection
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pre_cnt <= '0;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
      end else begin
         pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
         inc_q   <= inc_i;
         dec_q   <= dec_i;
      end
   end

   // Step requests: immediate on a key edge, then one per tick after the repeat delay
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rep_cnt   <= '0;
         step_q    <= 1'b0;
         step_up_q <= 1'b0;
      end else begin
         step_q <= 1'b0;
         if ((state != ST_EDIT) || !one_key) begin
            rep_cnt <= '0;
         end else if (rise) begin
            rep_cnt   <= '0;
            step_q    <= 1'b1;
            step_up_q <= inc_i;
         end else if (tick) begin
            if (rep_cnt < REP_LAST) begin
               rep_cnt <= rep_cnt + 1'b1;
            end else begin
               step_q    <= 1'b1;
               step_up_q <= inc_i;
            end
         end
      end
   end

   // FSM and datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         field_q <= 4'd0;
         value_q <= 8'h00;
         wr_q    <= 1'b0;
         addr_q  <= 4'd0;
         data_q  <= 8'h00;
      end else begin
         state   <= state_nxt;
         field_q <= field_nxt;
         value_q <= value_nxt;
         wr_q    <= wr_nxt;
         addr_q  <= addr_nxt;
         data_q  <= data_nxt;
      end
   end

   // Next-state logic; a field change or commit pre-empts any pending step
   always_comb begin
      state_nxt = state;
      field_nxt = field_q;
      value_nxt = value_q;
      wr_nxt    = wr_q;
      addr_nxt  = addr_q;
      data_nxt  = data_q;
      case (state)
         ST_IDLE: begin
            if (field_valid(sel_i)) begin
               state_nxt = ST_LOAD;
               field_nxt = sel_i;
            end
         end
         ST_LOAD: begin
            value_nxt = load_clamp(cur_i, field_lo, field_hi);
            state_nxt = ST_EDIT;
         end
         ST_EDIT: begin
            if (!field_valid(sel_i)) begin
               state_nxt = ST_IDLE;
            end else if (sel_i != field_q) begin
               state_nxt = ST_LOAD;
               field_nxt = sel_i;
            end else if (commit_i) begin
               state_nxt = ST_WRITE;
               wr_nxt    = 1'b1;
               addr_nxt  = field_q;
               data_nxt  = value_q;
            end else if (step_q) begin
               value_nxt = step_val;
            end
         end
         ST_WRITE: begin
            if (wr_ack_i) begin
               state_nxt = ST_EDIT;
               wr_nxt    = 1'b0;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign value_o   = value_q;
   assign wr_o      = wr_q;
   assign wr_addr_o = addr_q;
   assign wr_data_o = data_q;
   assign busy_o    = (state == ST_EDIT) || (state == ST_WRITE);

endmodule
